// File: rtl/pipelined_shifter_if.sv
// Stream interface of the pipelined shift/rotate unit: operand side
// (in_*) and result side (out_*) valid/ready handshakes.
interface pipelined_shifter_if #(
    parameter int WIDTH = 8
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amt;
    logic [2:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             err;

    // Producer/consumer side driving operands and accepting results.
    modport master (
        output in_valid, data_in, shift_amt, mode, out_ready,
        input  in_ready, out_valid, result, carry, err
    );

    // The shifter itself.
    modport slave (
        input  in_valid, data_in, shift_amt, mode, out_ready,
        output in_ready, out_valid, result, carry, err
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit. Shift-amount bit i is applied in stage
// (i*STAGES)/SHW; each stage register carries the partial result, the
// amount, mode, running carry, error flag and a valid bit. Stages load
// when empty or when their content moves on, so bubbles collapse.
module pipelined_shifter #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic             valid_r     [STAGES];
    logic [WIDTH-1:0] data_r      [STAGES];
    logic [SHW-1:0]   amt_r       [STAGES];
    logic [2:0]       mode_r      [STAGES];
    logic             carry_r     [STAGES];
    logic             err_r       [STAGES];

    logic             src_valid_s [STAGES];
    logic [WIDTH-1:0] src_data_s  [STAGES];
    logic [SHW-1:0]   src_amt_s   [STAGES];
    logic [2:0]       src_mode_s  [STAGES];
    logic             src_carry_s [STAGES];
    logic             src_err_s   [STAGES];
    logic [WIDTH:0]   nxt_s       [STAGES];
    logic             can_load_s  [STAGES];
    logic [WIDTH:0]   acc_s;
    logic [SHW-1:0]   amt_bits_s;
    logic             down_ready_s;

    // One sub-shift by k positions; returns {carry_out, value}. The carry
    // is the last bit pushed out by this sub-shift. Unknown modes pass
    // the value and incoming carry through untouched.
    function automatic logic [WIDTH:0] sub_shift(
        input logic [WIDTH-1:0] d,
        input logic             c,
        input logic [2:0]       m,
        input int               k
    );
        logic [WIDTH:0]   w;
        logic [WIDTH-1:0] r;
        logic             co;
        w  = '0;
        r  = d;
        co = c;
        case (m)
            3'd0: begin
                w  = {1'b0, d} << k;
                r  = w[WIDTH-1:0];
                co = w[WIDTH];
            end
            3'd1: begin
                w  = {d, 1'b0} >> k;
                r  = w[WIDTH:1];
                co = w[0];
            end
            3'd2: begin
                w  = $unsigned($signed({d, 1'b0}) >>> k);
                r  = w[WIDTH:1];
                co = w[0];
            end
            3'd3: begin
                r  = (d << k) | (d >> (WIDTH - k));
                co = r[0];
            end
            3'd4: begin
                r  = (d >> k) | (d << (WIDTH - k));
                co = r[WIDTH-1];
            end
            default: begin
                r  = d;
                co = c;
            end
        endcase
        return {co, r};
    endfunction

    // Stage inputs: stage 0 takes the bus, later stages take the previous register.
    always_comb begin
        src_valid_s[0] = bus.in_valid;
        src_data_s[0]  = bus.data_in;
        src_amt_s[0]   = bus.shift_amt;
        src_mode_s[0]  = bus.mode;
        src_carry_s[0] = 1'b0;
        src_err_s[0]   = (bus.mode > 3'd4);
        for (int s = 1; s < STAGES; s++) begin
            src_valid_s[s] = valid_r[s-1];
            src_data_s[s]  = data_r[s-1];
            src_amt_s[s]   = amt_r[s-1];
            src_mode_s[s]  = mode_r[s-1];
            src_carry_s[s] = carry_r[s-1];
            src_err_s[s]   = err_r[s-1];
        end
    end

    // Per-stage shift network: apply the amount bits owned by each stage, lowest first.
    always_comb begin
        acc_s      = '0;
        amt_bits_s = '0;
        for (int s = 0; s < STAGES; s++) begin
            acc_s = {src_carry_s[s], src_data_s[s]};
            for (int i = 0; i < SHW; i++) begin
                amt_bits_s = src_amt_s[s] >> i;
                if ((((i * STAGES) / SHW) == s) && amt_bits_s[0]) begin
                    acc_s = sub_shift(acc_s[WIDTH-1:0], acc_s[WIDTH], src_mode_s[s], 1 << i);
                end else begin
                    acc_s = acc_s;
                end
            end
            nxt_s[s] = acc_s;
        end
    end

    // Back-pressure chain: a stage can load when empty or when it advances downstream.
    always_comb begin
        down_ready_s = bus.out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            can_load_s[s] = !valid_r[s] || down_ready_s;
            down_ready_s  = can_load_s[s];
        end
    end

    assign bus.in_ready  = rst_n && can_load_s[0];
    assign bus.out_valid = valid_r[STAGES-1];
    assign bus.result    = data_r[STAGES-1];
    assign bus.carry     = carry_r[STAGES-1];
    assign bus.err       = err_r[STAGES-1];

    // Stage registers: clear on reset, otherwise load the upstream slot when allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                valid_r[s] <= 1'b0;
                data_r[s]  <= '0;
                amt_r[s]   <= '0;
                mode_r[s]  <= 3'd0;
                carry_r[s] <= 1'b0;
                err_r[s]   <= 1'b0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (can_load_s[s]) begin
                    valid_r[s] <= src_valid_s[s];
                    if (src_valid_s[s]) begin
                        data_r[s]  <= nxt_s[s][WIDTH-1:0];
                        carry_r[s] <= nxt_s[s][WIDTH];
                        amt_r[s]   <= src_amt_s[s];
                        mode_r[s]  <= src_mode_s[s];
                        err_r[s]   <= src_err_s[s];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (WIDTH=8, STAGES=2): directed
// scenarios plus a randomized stream compared against a whole-amount model.
module tb_pipelined_shifter;
    localparam int WIDTH  = 8;
    localparam int STAGES = 2;
    localparam int SHW    = $clog2(WIDTH);

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    int               acc_q[$];
    logic [WIDTH+1:0] got_q[$];
    int               got_cyc_q[$];

    pipelined_shifter_if #(.WIDTH(WIDTH)) bus ();
    pipelined_shifter #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepts and consumed results mid-cycle, where inputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back({bus.err, bus.carry, bus.result});
                got_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: apply the whole amount at once; returns {err, carry, result}.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] d, input int amt, input logic [2:0] m);
        logic [WIDTH-1:0] r, t;
        logic c;
        r = d;
        c = 1'b0;
        case (m)
            3'd0: begin r = d << amt; t = d >> (WIDTH - amt); c = (amt > 0) ? t[0] : 1'b0; end
            3'd1: begin r = d >> amt; t = d >> (amt - 1); c = (amt > 0) ? t[0] : 1'b0; end
            3'd2: begin r = $signed(d) >>> amt; t = d >> (amt - 1); c = (amt > 0) ? t[0] : 1'b0; end
            3'd3: begin r = (d << amt) | (d >> (WIDTH - amt)); c = (amt > 0) ? r[0] : 1'b0; end
            3'd4: begin r = (d >> amt) | (d << (WIDTH - amt)); c = (amt > 0) ? r[WIDTH-1] : 1'b0; end
            default: return {1'b1, 1'b0, d};
        endcase
        return {1'b0, c, r};
    endfunction

    task automatic clear_logs();
        acc_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int amt, input logic [2:0] m, output bit ok);
        bus.in_valid  = 1'b1;
        bus.data_in   = d;
        bus.shift_amt = SHW'(amt);
        bus.mode      = m;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_results(input int n, output bit ok);
        ok = (got_q.size() >= n);
        for (int t = 0; t < 400 && !ok; t++) begin
            @(posedge clk);
            #1;
            ok = (got_q.size() >= n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.data_in = 8'hA5; bus.shift_amt = 3'd1; bus.mode = 3'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL rst_result: got %h want 00", bus.result); end
        checks++; if (bus.carry !== 1'b0) begin failures++; $display("FAIL rst_carry: got %b want 0", bus.carry); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", bus.err); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready: got %b want 1", bus.in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_modes();
        logic [9:0] exp_v [5];
        bit ok, all_ok;
        exp_v = '{10'h0B0, 10'h112, 10'h1F2, 10'h0B4, 10'h1D2};
        clear_logs();
        all_ok = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin send(8'h96, 3, 3'(i), ok); all_ok &= ok; end
        bus.in_valid = 1'b0;
        wait_results(5, ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL modes_handshake: got timeout want 5 results"); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_v[i]) begin failures++; $display("FAIL modes_result[%0d]: got %h want %h", i, got_q[i], exp_v[i]); end
            checks++; if (got_cyc_q[i] - acc_q[i] !== STAGES) begin failures++; $display("FAIL modes_latency[%0d]: got %0d want %0d", i, got_cyc_q[i] - acc_q[i], STAGES); end
            checks++; if (got_cyc_q[i] !== got_cyc_q[0] + i) begin failures++; $display("FAIL modes_back_to_back[%0d]: got cycle %0d want %0d", i, got_cyc_q[i], got_cyc_q[0] + i); end
        end
    endtask

    task automatic test_edge_amounts();
        logic [2:0] m_v [8];
        int         a_v [8];
        logic [9:0] exp_v [8];
        bit ok, all_ok;
        m_v   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd0, 3'd4};
        a_v   = '{0, 0, 0, 0, 0, 7, 7, 7};
        exp_v = '{10'h081, 10'h081, 10'h081, 10'h081, 10'h081, 10'h0FF, 10'h080, 10'h003};
        clear_logs();
        all_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin send(8'h81, a_v[i], m_v[i], ok); all_ok &= ok; end
        bus.in_valid = 1'b0;
        wait_results(8, ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL edge_handshake: got timeout want 8 results"); end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_v[i]) begin failures++; $display("FAIL edge_result[%0d]: got %h want %h", i, got_q[i], exp_v[i]); end
        end
    endtask

    task automatic test_illegal_mode();
        bit ok, all_ok;
        clear_logs();
        all_ok = 1'b1;
        send(8'h5A, 4, 3'd6, ok); all_ok &= ok;
        send(8'h5A, 1, 3'd0, ok); all_ok &= ok;
        bus.in_valid = 1'b0;
        wait_results(2, ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL illegal_handshake: got timeout want 2 results"); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0] !== 10'h25A) begin failures++; $display("FAIL illegal_result: got %h want 25a", got_q[0]); end
            checks++; if (got_q[1] !== 10'h0B4) begin failures++; $display("FAIL illegal_next_legal: got %h want 0b4", got_q[1]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [9:0] exp_v [4];
        bit ok, all_ok;
        clear_logs();
        all_ok = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_v[i] = model(8'($urandom), i + 1, 3'(i));
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(exp_v[i][7:0] ^ 8'h00, i + 1, 3'(i), ok);
                    all_ok &= ok;
                end
                bus.in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                checks++; if (acc_q.size() !== 2) begin failures++; $display("FAIL bp_accepts_stalled: got %0d want 2", acc_q.size()); end
                checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready); end
                checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid_held: got %b want 1", bus.out_valid); end
                bus.out_ready = 1'b1;
            end
        join
        // exp_v[i][7:0] was reused as the operand, so rebuild the expectations from it
        for (int i = 0; i < 4; i++) exp_v[i] = model(exp_v[i][7:0], i + 1, 3'(i));
        wait_results(4, ok); all_ok &= ok;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (!all_ok) begin failures++; $display("FAIL bp_handshake: got timeout want 4 results"); end
        checks++; if (acc_q.size() !== 4) begin failures++; $display("FAIL bp_accept_once: got %0d want 4", acc_q.size()); end
        checks++; if (got_q.size() !== 4) begin failures++; $display("FAIL bp_no_duplicates: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_v[i]) begin failures++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_v[i]); end
        end
    endtask

    task automatic test_reset_midstream();
        bit ok, all_ok;
        clear_logs();
        all_ok = 1'b1;
        bus.out_ready = 1'b0;
        send(8'hFF, 1, 3'd0, ok); all_ok &= ok;
        send(8'h3C, 2, 3'd3, ok); all_ok &= ok;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight: got %b want 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
        checks++; if ({bus.err, bus.carry, bus.result} !== 10'h000) begin failures++; $display("FAIL mid_outputs: got %h want 000", {bus.err, bus.carry, bus.result}); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        clear_logs();
        repeat (5) @(posedge clk);
        #1;
        checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL mid_stale: got %0d results want 0", got_q.size()); end
        send(8'h02, 1, 3'd1, ok); all_ok &= ok;
        bus.in_valid = 1'b0;
        wait_results(1, ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL mid_handshake: got timeout want result"); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== 10'h001) begin failures++; $display("FAIL mid_fresh: got %h want 001", got_q[0]); end
        end
    endtask

    task automatic test_random();
        logic [9:0] exp_q[$];
        logic [7:0] d;
        int amt, n_bad;
        logic [2:0] m;
        bit ok, all_ok, done;
        localparam int N = 2000;
        clear_logs();
        all_ok = 1'b1;
        done = 1'b0;
        n_bad = 0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    d   = 8'($urandom);
                    amt = $urandom_range(0, WIDTH - 1);
                    m   = 3'($urandom_range(0, 7));
                    send(d, amt, m, ok);
                    all_ok &= ok;
                    if (ok) exp_q.push_back(model(d, amt, m));
                end
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_results(exp_q.size(), ok); all_ok &= ok;
        checks++; if (!all_ok) begin failures++; $display("FAIL rand_handshake: got timeout want %0d results", N); end
        checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                n_bad++;
                if (n_bad <= 10) $display("FAIL rand_result[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_modes();
        test_edge_amounts();
        test_illegal_mode();
        test_back_pressure();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_shifter.md
# pipelined_shifter

Parametrised, pipelined shift/rotate unit with a valid/ready stream interface. It takes a WIDTH-bit operand, a shift amount and a mode code, and produces logical-left, logical-right, arithmetic-right, rotate-left or rotate-right results, plus a carry-out and an illegal-mode flag. The shift network is split across STAGES register stages with full back-pressure support. It replaces the fixed 8-bit, purely combinational constant-shift block in the datapath library.

## Interface
Parameters:
- WIDTH, 8, operand width; power of two, at least 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- STAGES, 2, number of pipeline register stages; 1 ≤ STAGES ≤ SHW.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept an input this cycle.
- data_in  in  WIDTH  operand.
- shift_amt  in  SHW  shift distance, 0..WIDTH-1.
- mode  in  3  operation: 0 SHL, 1 SHR (logical), 2 SAR (arithmetic), 3 ROL, 4 ROR; 5..7 illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  shifted or rotated value.
- carry  out  1  last bit shifted or rotated out.
- err  out  1  illegal mode code for this result.

## Operation
- Handshake: an input is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- in_valid, data_in, shift_amt and mode must stay stable while in_valid && !in_ready.
- Shift decomposition: amount bit i is applied in stage floor(i*STAGES/SHW), in ascending i. Each stage register holds the partial result, the remaining amount bits, mode, carry and a valid bit.
- Stage advance: a stage loads when its register is empty or its content moves forward in the same cycle. Bubbles collapse, so there is no gap between results when out_ready=1.
- in_ready is combinational: 1 when stage 0 is empty or advancing; forced 0 while rst_n=0.
- SHL: zeros fill the LSBs. carry = data_in[WIDTH-amt].
- SHR: zeros fill the MSBs. carry = data_in[amt-1].
- SAR: data_in[WIDTH-1] fills the MSBs. carry = data_in[amt-1].
- ROL: carry = result[0].
- ROR: carry = result[WIDTH-1].
- amt = 0: result = data_in and carry = 0, for every legal mode.
- Illegal mode (5..7): result = data_in, carry = 0, err = 1. The transaction is still accepted and flows through the pipeline normally.
- Carry is tracked per stage: each sub-shift updates it with the last bit it shifted out, and a sub-shift of zero leaves it unchanged.
- result, carry and err are held while out_valid && !out_ready.

## Timing
- Latency: an input accepted at edge N gives out_valid=1 after edge N+STAGES when the pipeline is not stalled.
- Throughput: one result per cycle while out_ready=1.
- Capacity: exactly STAGES transactions in flight. When all stages are full and out_ready=0, in_ready=0.
- Simultaneous accept and consume in a full pipeline: allowed, with no loss and no duplication.
- Reset (asynchronous, any time, including mid-stream): all valid bits clear immediately.
  - out_valid=0, result=0, carry=0, err=0, in_ready=0.
  - In-flight transactions are discarded.
  - in_ready rises to 1 in the first cycle after rst_n deasserts.
- No combinational path from in_valid to out_valid. The only combinational path from out_ready is out_ready → in_ready.

## Test plan
Directed scenarios, run with WIDTH=8 and STAGES=2 unless stated otherwise:
- **All modes:** data_in=0x96, amt=3, out_ready=1, in order:
  - SHL → 0xB0, c0.
  - SHR → 0x12, c1.
  - SAR → 0xF2, c1.
  - ROL → 0xB4, c0.
  - ROR → 0xD2, c1.
  - Each result appears 2 cycles after its accept, back-to-back.
- **Edge amounts:** data_in=0x81.
  - amt=0, any legal mode → 0x81, c0.
  - SAR 7 → 0xFF, c0.
  - SHL 7 → 0x80, c0.
  - ROR 7 → 0x03, c0.
- **Illegal mode:** mode=6, data_in=0x5A, amt=4 → result=0x5A, err=1, carry=0. The next legal input returns err=0.
- **Back-pressure:** stream 4 inputs with out_ready=0.
  - in_ready drops after 2 accepts.
  - Raising out_ready drains the results in order, with no duplicates.
  - Inputs held stable while stalled are accepted exactly once.
- **Reset mid-stream:** pull rst_n low asynchronously with 2 transactions in flight.
  - Outputs clear at once, and no stale result appears after release.
  - A fresh SHR 1 of 0x02 returns 0x01, c0.
- **Parameter sweep:** WIDTH ∈ {8, 16, 32}, STAGES ∈ {1, SHW}, 10k random transactions with random out_ready, checked against a reference model. Latency equals STAGES when unstalled.
